// File: rtl/dmem_bytelane.sv
// dmem_bytelane: single-port word-organised data memory with byte-lane
// load/store support, little-endian lane order and sign/zero extension.
// After reset the array is zeroed one word per cycle (CLEAR) before any
// request is accepted (IDLE). Every accepted request returns one
// registered response on the following cycle.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   req_valid    request present
//   req_ready    request accepted this cycle (IDLE)
//   req_we       1 = store, 0 = load
//   req_size     00 word, 01 half, 10 byte, 11 illegal
//   req_unsigned load zero-extends when 1, sign-extends when 0
//   req_addr     byte address (wraps modulo 4*DEPTH)
//   req_wdata    store data, right-justified
//   rsp_valid    one-cycle response pulse
//   rsp_rdata    load result, 0 otherwise
//   rsp_err      misaligned or illegal-size request
//   busy         memory clear in progress
module dmem_bytelane #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  logic [31:0] mem [DEPTH];

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word;
  logic [31:0]      wr_word;
  logic [31:0]      ld_data;
  logic [15:0]      half_sel;
  logic [7:0]       byte_sel;
  logic             bad;
  logic             accept;
  logic             st_en;

  // Upper address bits are intentionally ignored (address wraps).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];

  assign idx     = req_addr[IDX_W+1:2];
  assign lane    = req_addr[1:0];
  assign rd_word = mem[idx];

  // FSM: state and clear index
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        // Leave CLEAR on the same edge that zeroes the last word.
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end
      end
      IDLE: begin
        req_ready = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign accept = req_valid && (state_q == IDLE);

  // Alignment / legality check
  always_comb begin
    bad = 1'b0;
    case (req_size)
      2'b00:   bad = (lane != 2'b00);
      2'b01:   bad = lane[0];
      2'b10:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
  end

  assign st_en = accept && req_we && !bad;

  // Load lane selection and extension
  always_comb begin
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (lane)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    case (req_size)
      2'b00:   ld_data = rd_word;
      2'b01:   ld_data = req_unsigned ? {16'h0000, half_sel}
                                      : {{16{half_sel[15]}}, half_sel};
      2'b10:   ld_data = req_unsigned ? {24'h000000, byte_sel}
                                      : {{24{byte_sel[7]}}, byte_sel};
      default: ld_data = '0;
    endcase
  end

  // Store merge: untouched lanes keep their current contents.
  always_comb begin
    wr_word = rd_word;
    case (req_size)
      2'b00: wr_word = req_wdata;
      2'b01: begin
        if (lane[1]) wr_word[31:16] = req_wdata[15:0];
        else         wr_word[15:0]  = req_wdata[15:0];
      end
      2'b10: begin
        case (lane)
          2'd0:    wr_word[7:0]   = req_wdata[7:0];
          2'd1:    wr_word[15:8]  = req_wdata[7:0];
          2'd2:    wr_word[23:16] = req_wdata[7:0];
          default: wr_word[31:24] = req_wdata[7:0];
        endcase
      end
      default: wr_word = rd_word;
    endcase
  end

  // Memory array: clear sweep or store
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem[clr_idx_q] <= '0;
      end else if (st_en) begin
        mem[idx] <= wr_word;
      end
    end
  end

  // Registered response
  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept && bad;
    rsp_rdata_d = (accept && !bad && !req_we) ? ld_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
